// File: rtl/mc_control_112.sv
// Multicycle MIPS-subset main control FSM: sequences IFETCH/DECODE/execute/writeback
// and decodes Moore-style datapath strobes from the current state plus opcode/funct.
module mc_control_112 (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWr,
    output logic       PCWrCond,
    output logic       IorD,
    output logic       MemWr,
    output logic       IRWr,
    output logic       RegDst,
    output logic       RegWr,
    output logic       ExtOp,
    output logic       ALUSrcA,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUctr,
    output logic [3:0] state,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        IFETCH   = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] r_ctr;
    logic       r_legal;
    logic       add_ovf;
    logic       unused_zero;

    // Zero only qualifies PCWrCond inside the datapath; control never branches on it.
    assign unused_zero = Zero;
    assign state       = state_q;
    assign add_ovf     = (funct == 6'b100000) & Overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IFETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        r_ctr   = 3'b000;
        r_legal = 1'b1;
        case (funct)
            6'b100001: r_ctr = 3'b000;
            6'b100000: r_ctr = 3'b001;
            6'b100011: r_ctr = 3'b010;
            6'b100100: r_ctr = 3'b011;
            6'b100101: r_ctr = 3'b100;
            6'b101010: r_ctr = 3'b101;
            default:   r_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = IFETCH;
        PCWr       = 1'b0;
        PCWrCond   = 1'b0;
        IorD       = 1'b0;
        MemWr      = 1'b0;
        IRWr       = 1'b0;
        RegDst     = 1'b0;
        RegWr      = 1'b0;
        ExtOp      = 1'b0;
        ALUSrcA    = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUctr     = 3'b000;
        instr_done = 1'b0;
        case (state_q)
            IFETCH: begin
                IRWr    = 1'b1;
                ALUSrcB = 2'b01;
                PCWr    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                case (opcode)
                    OP_R:             state_d = EXEC_R;
                    OP_LW, OP_SW:     state_d = MEM_ADDR;
                    OP_ADDIU, OP_ORI: state_d = EXEC_I;
                    OP_BEQ:           state_d = BRANCH;
                    OP_J:             state_d = JUMP;
                    default:          instr_done = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                if (opcode == OP_SW) begin
                    state_d = MEM_WR;
                end else if (opcode == OP_LW) begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                IorD    = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                IorD       = 1'b1;
                MemWr      = 1'b1;
                instr_done = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUctr  = r_ctr;
                if (r_legal) begin
                    state_d = R_WB;
                end else begin
                    instr_done = 1'b1;
                end
            end
            R_WB: begin
                RegDst     = 1'b1;
                ALUctr     = r_ctr;
                RegWr      = ~add_ovf;
                instr_done = 1'b1;
            end
            EXEC_I, I_WB: begin
                if (opcode == OP_ORI) begin
                    ALUctr = 3'b100;
                end else begin
                    ExtOp = 1'b1;
                end
                if (state_q == EXEC_I) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = I_WB;
                end else begin
                    RegWr      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUctr     = 3'b010;
                PCWrCond   = 1'b1;
                PCSrc      = 2'b01;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCWr       = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset holds state at IFETCH, so its write strobes must be masked off.
        if (rst) begin
            PCWr       = 1'b0;
            PCWrCond   = 1'b0;
            MemWr      = 1'b0;
            IRWr       = 1'b0;
            RegWr      = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_112.sv
// Scoreboard bench for mc_control_112: directed instruction vectors push per-cycle
// expected state/outputs; a negedge monitor pops and compares.
module tb_mc_control_112;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       Zero, Overflow;
    logic       PCWr, PCWrCond, IorD, MemWr, IRWr, RegDst, RegWr, ExtOp, ALUSrcA, MemtoReg;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUctr;
    logic [3:0] state;
    logic       instr_done;

    mc_control_112 dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero), .Overflow(Overflow),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemWr(MemWr), .IRWr(IRWr),
        .RegDst(RegDst), .RegWr(RegWr), .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUctr(ALUctr), .state(state), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    localparam logic B1 = 1'b1;
    localparam logic B0 = 1'b0;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ov;
        logic [17:0] mask;
        logic [7:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    int          done_cnt = 0;

    logic [5:0]  v_op [16];
    logic [5:0]  v_fn [16];
    logic        v_z  [16];
    logic        v_ovf[16];
    int          v_len[16];
    logic [3:0]  v_st [16][5];
    logic [17:0] v_out[16][5];
    logic [17:0] r_if, r_dec, r_strobes;

    logic [17:0] dut_vec;
    assign dut_vec = {PCWr, PCWrCond, IorD, MemWr, IRWr, RegDst, RegWr, ExtOp, ALUSrcA, MemtoReg,
                      ALUSrcB, PCSrc, ALUctr, instr_done};

    function automatic logic [17:0] o(input logic pcwr, pcwrc, iord, memwr, irwr, regdst, regwr,
                                      extop, srca, m2r, input logic [1:0] srcb, pcsrc,
                                      input logic [2:0] ctr, input logic done);
        return {pcwr, pcwrc, iord, memwr, irwr, regdst, regwr, extop, srca, m2r, srcb, pcsrc, ctr, done};
    endfunction

    task automatic row(input int i, input int r, input logic [3:0] s, input logic [17:0] ov);
        v_st[i][r]  = s;
        v_out[i][r] = ov;
    endtask

    task automatic hdr(input int i, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic ovf, input int len);
        v_op[i] = op; v_fn[i] = fn; v_z[i] = z; v_ovf[i] = ovf; v_len[i] = len;
        row(i, 0, 4'd0, r_if);
        row(i, 1, 4'd1, r_dec);
    endtask

    task automatic rvec(input int i, input logic [5:0] fn, input logic ovf, input logic [2:0] c,
                        input logic w);
        hdr(i, 6'b000000, fn, B0, ovf, 4);
        row(i, 2, 4'd6, o(B0,B0,B0,B0,B0,B0,B0,B0,B1,B0,2'b00,2'b00,c,B0));
        row(i, 3, 4'd7, o(B0,B0,B0,B0,B0,B1,w,B0,B0,B0,2'b00,2'b00,c,B1));
    endtask

    task automatic setup();
        r_if      = o(B1,B0,B0,B0,B1,B0,B0,B0,B0,B0,2'b01,2'b00,3'b000,B0);
        r_dec     = o(B0,B0,B0,B0,B0,B0,B0,B1,B0,B0,2'b11,2'b00,3'b000,B0);
        r_strobes = o(B1,B1,B0,B1,B1,B0,B1,B0,B0,B0,2'b00,2'b00,3'b000,B1);
        // lw / sw
        hdr(0, 6'b100011, 6'b000000, B0, B0, 5);
        row(0, 2, 4'd2, o(B0,B0,B0,B0,B0,B0,B0,B1,B1,B0,2'b10,2'b00,3'b000,B0));
        row(0, 3, 4'd3, o(B0,B0,B1,B0,B0,B0,B0,B0,B0,B0,2'b00,2'b00,3'b000,B0));
        row(0, 4, 4'd4, o(B0,B0,B0,B0,B0,B0,B1,B0,B0,B1,2'b00,2'b00,3'b000,B1));
        hdr(1, 6'b101011, 6'b000000, B0, B0, 4);
        row(1, 2, 4'd2, o(B0,B0,B0,B0,B0,B0,B0,B1,B1,B0,2'b10,2'b00,3'b000,B0));
        row(1, 3, 4'd5, o(B0,B0,B1,B1,B0,B0,B0,B0,B0,B0,2'b00,2'b00,3'b000,B1));
        // R-type: add with/without overflow, then the other legal functs
        rvec(2, 6'b100000, B1, 3'b001, B0);
        rvec(3, 6'b100000, B0, 3'b001, B1);
        rvec(4, 6'b100001, B1, 3'b000, B1);
        rvec(5, 6'b100011, B0, 3'b010, B1);
        rvec(6, 6'b100100, B0, 3'b011, B1);
        rvec(7, 6'b100101, B0, 3'b100, B1);
        rvec(8, 6'b101010, B1, 3'b101, B1);
        // unlisted funct ends in EXEC_R without a write
        hdr(9, 6'b000000, 6'b000000, B0, B0, 3);
        row(9, 2, 4'd6, o(B0,B0,B0,B0,B0,B0,B0,B0,B1,B0,2'b00,2'b00,3'b000,B1));
        // addiu / ori
        hdr(10, 6'b001001, 6'b000000, B0, B0, 4);
        row(10, 2, 4'd8, o(B0,B0,B0,B0,B0,B0,B0,B1,B1,B0,2'b10,2'b00,3'b000,B0));
        row(10, 3, 4'd9, o(B0,B0,B0,B0,B0,B0,B1,B1,B0,B0,2'b00,2'b00,3'b000,B1));
        hdr(11, 6'b001101, 6'b000000, B0, B0, 4);
        row(11, 2, 4'd8, o(B0,B0,B0,B0,B0,B0,B0,B0,B1,B0,2'b10,2'b00,3'b100,B0));
        row(11, 3, 4'd9, o(B0,B0,B0,B0,B0,B0,B1,B0,B0,B0,2'b00,2'b00,3'b100,B1));
        // beq taken / not taken look identical to control
        hdr(12, 6'b000100, 6'b000000, B1, B0, 3);
        row(12, 2, 4'd10, o(B0,B1,B0,B0,B0,B0,B0,B0,B1,B0,2'b00,2'b01,3'b010,B1));
        hdr(13, 6'b000100, 6'b000000, B0, B0, 3);
        row(13, 2, 4'd10, o(B0,B1,B0,B0,B0,B0,B0,B0,B1,B0,2'b00,2'b01,3'b010,B1));
        hdr(14, 6'b000010, 6'b000000, B0, B0, 3);
        row(14, 2, 4'd11, o(B1,B0,B0,B0,B0,B0,B0,B0,B0,B0,2'b00,2'b10,3'b000,B1));
        // illegal opcode retires in DECODE
        hdr(15, 6'b111111, 6'b000000, B0, B0, 2);
        row(15, 1, 4'd1, o(B0,B0,B0,B0,B0,B0,B0,B1,B0,B0,2'b11,2'b00,3'b000,B1));
    endtask

    task automatic push_row(input int i, input int r);
        exp_t e;
        e.st = v_st[i][r]; e.ov = v_out[i][r]; e.mask = '1; e.tag = i[7:0];
        exp_q.push_back(e);
    endtask

    task automatic push_reset();
        exp_t e;
        e.st = 4'd0; e.ov = '0; e.mask = r_strobes; e.tag = 8'd255;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int i);
        opcode = v_op[i]; funct = v_fn[i]; Zero = v_z[i]; Overflow = v_ovf[i];
    endtask

    // Called at posedge+1 of an IFETCH cycle; returns at posedge+1 of the next IFETCH.
    task automatic issue(input int i);
        drive(i);
        for (int r = 0; r < v_len[i]; r++) push_row(i, r);
        issued++;
        repeat (v_len[i]) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        checks++;
        if (MemWr && RegWr) begin
            errors++;
            $display("FAIL mutex: MemWr=%b RegWr=%b both set at %0t", MemWr, RegWr, $time);
        end
        if (!rst && instr_done) done_cnt++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (state !== mon_e.st) begin
                errors++;
                $display("FAIL state vec=%0d: got %0d want %0d at %0t", mon_e.tag, state, mon_e.st, $time);
            end
            checks++;
            if ((dut_vec & mon_e.mask) !== (mon_e.ov & mon_e.mask)) begin
                errors++;
                $display("FAIL outputs vec=%0d state=%0d: got %b want %b (mask %b) at %0t",
                         mon_e.tag, state, dut_vec, mon_e.ov, mon_e.mask, $time);
            end
        end
    end

    initial begin
        int drain;
        rst = 1'b1; opcode = '0; funct = '0; Zero = 1'b0; Overflow = 1'b0;
        setup();
        @(posedge clk); #1;
        push_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) issue(i);

        // Async reset while sw sits in MEM_ADDR: state drops before any edge, no store follows.
        drive(1);
        push_row(1, 0);
        push_row(1, 1);
        repeat (2) @(posedge clk);
        #1;
        #1 rst = 1'b1;
        push_reset();
        @(posedge clk); #1;
        push_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 40; n++) issue(int'($urandom_range(15, 0)));

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt != issued) begin
            errors++;
            $display("FAIL done_count: got %0d want %0d", done_cnt, issued);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
